// File: rtl/mrh_l2_responder.sv
// In-order request/response responder in front of a word-addressed backing store.
// Optional out-of-range error reporting is enabled by defining MRH_L2_RESP_ERR_EN.
module mrh_l2_responder #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int TAG_W     = 4,
   parameter int MEM_WORDS = 256,
   parameter int QDEPTH    = 4,
   parameter int LATENCY   = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   input  logic              i_req_cmd,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [TAG_W-1:0]  i_req_tag,
   input  logic [DATA_W-1:0] i_req_data,
   output logic              o_req_ready,
   output logic              o_resp_valid,
   output logic [TAG_W-1:0]  o_resp_tag,
   output logic [DATA_W-1:0] o_resp_data,
`ifdef MRH_L2_RESP_ERR_EN
   output logic              o_resp_err,
`endif
   input  logic              i_resp_ready
);

   localparam int PTR_W = $clog2(QDEPTH) + 1;
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = $clog2(LATENCY + 1);

   localparam logic [0:0] ST_WAIT = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   logic              fifo_cmd_q  [QDEPTH];
   logic [ADDR_W-1:0] fifo_addr_q [QDEPTH];
   logic [TAG_W-1:0]  fifo_tag_q  [QDEPTH];
   logic [DATA_W-1:0] fifo_data_q [QDEPTH];
   logic [DATA_W-1:0] mem_q       [MEM_WORDS];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              init_q;
   logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
`ifdef MRH_L2_RESP_ERR_EN
   logic              resp_err_q, resp_err_d;
`endif

   logic              full, empty, push, pop, mem_we;
   logic              head_cmd, head_oob;
   logic [ADDR_W-1:0] head_addr, head_word;
   logic [TAG_W-1:0]  head_tag;
   logic [DATA_W-1:0] head_data;
   logic [IDX_W-1:0]  head_idx;

   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // Ready is forced low combinationally during reset and stays low one more cycle via init_q.
   assign o_req_ready = init_q & ~full & ~i_reset;
   assign push        = i_req_valid & o_req_ready;

   assign head_cmd  = fifo_cmd_q[rd_ptr_q[PTR_W-2:0]];
   assign head_addr = fifo_addr_q[rd_ptr_q[PTR_W-2:0]];
   assign head_tag  = fifo_tag_q[rd_ptr_q[PTR_W-2:0]];
   assign head_data = fifo_data_q[rd_ptr_q[PTR_W-2:0]];
   assign head_word = head_addr >> 3;
   assign head_idx  = head_word[IDX_W-1:0];

`ifdef MRH_L2_RESP_ERR_EN
   assign head_oob   = (head_word >= ADDR_W'(MEM_WORDS));
   assign o_resp_err = resp_err_q;
`else
   // Without error reporting the upper word bits are dropped so addresses wrap.
   assign head_oob = 1'b0;
   wire unused_word_bits = ^head_word[ADDR_W-1:IDX_W];
`endif

   assign o_resp_valid = (state_q == ST_RESP);
   assign o_resp_tag   = resp_tag_q;
   assign o_resp_data  = resp_data_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      resp_tag_d  = resp_tag_q;
      resp_data_d = resp_data_q;
`ifdef MRH_L2_RESP_ERR_EN
      resp_err_d  = resp_err_q;
`endif
      mem_we      = 1'b0;
      pop         = 1'b0;
      unique case (state_q)
         ST_WAIT: begin
            // The head sits LATENCY full cycles after the cycle it arrived before the access fires.
            if (!empty) begin
               if (cnt_q == CNT_W'(LATENCY)) begin
                  state_d    = ST_RESP;
                  resp_tag_d = head_tag;
`ifdef MRH_L2_RESP_ERR_EN
                  resp_err_d = head_oob;
`endif
                  if (head_oob) begin
                     resp_data_d = '0;
                  end else if (head_cmd) begin
                     mem_we      = 1'b1;
                     resp_data_d = head_data;
                  end else begin
                     resp_data_d = mem_q[head_idx];
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            if (i_resp_ready) begin
               pop     = 1'b1;
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
      endcase
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_WAIT;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         init_q      <= 1'b0;
         resp_tag_q  <= '0;
         resp_data_q <= '0;
`ifdef MRH_L2_RESP_ERR_EN
         resp_err_q  <= 1'b0;
`endif
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem_q[i] <= DATA_W'(i);
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         init_q      <= 1'b1;
         resp_tag_q  <= resp_tag_d;
         resp_data_q <= resp_data_d;
`ifdef MRH_L2_RESP_ERR_EN
         resp_err_q  <= resp_err_d;
`endif
         if (mem_we) begin
            mem_q[head_idx] <= head_data;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_cmd_q[wr_ptr_q[PTR_W-2:0]]  <= i_req_cmd;
         fifo_addr_q[wr_ptr_q[PTR_W-2:0]] <= i_req_addr;
         fifo_tag_q[wr_ptr_q[PTR_W-2:0]]  <= i_req_tag;
         fifo_data_q[wr_ptr_q[PTR_W-2:0]] <= i_req_data;
      end
   end

endmodule

// File: tb/tb_mrh_l2_responder.sv
// Scoreboard bench for mrh_l2_responder: directed scenarios plus randomized traffic
// checked against a plain array/queue model of the backing store.
module tb_mrh_l2_responder;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int TAG_W     = 4;
   localparam int MEM_WORDS = 256;
   localparam int QDEPTH    = 4;
   localparam int LATENCY   = 3;

   logic              clk = 1'b0;
   logic              i_reset = 1'b1;
   logic              i_req_valid = 1'b0;
   logic              i_req_cmd = 1'b0;
   logic [ADDR_W-1:0] i_req_addr = '0;
   logic [TAG_W-1:0]  i_req_tag = '0;
   logic [DATA_W-1:0] i_req_data = '0;
   logic              o_req_ready;
   logic              o_resp_valid;
   logic [TAG_W-1:0]  o_resp_tag;
   logic [DATA_W-1:0] o_resp_data;
`ifdef MRH_L2_RESP_ERR_EN
   logic              o_resp_err;
`endif
   logic              i_resp_ready = 1'b0;

   always #5 clk = ~clk;

   mrh_l2_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
      .MEM_WORDS(MEM_WORDS), .QDEPTH(QDEPTH), .LATENCY(LATENCY)
   ) dut (
      .i_clk(clk),
      .i_reset(i_reset),
      .i_req_valid(i_req_valid),
      .i_req_cmd(i_req_cmd),
      .i_req_addr(i_req_addr),
      .i_req_tag(i_req_tag),
      .i_req_data(i_req_data),
      .o_req_ready(o_req_ready),
      .o_resp_valid(o_resp_valid),
      .o_resp_tag(o_resp_tag),
      .o_resp_data(o_resp_data),
`ifdef MRH_L2_RESP_ERR_EN
      .o_resp_err(o_resp_err),
`endif
      .i_resp_ready(i_resp_ready)
   );

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic              err;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] mem_m [MEM_WORDS];
   int                n_cmp = 0;
   int                n_fail = 0;
   int                rr_mode = 1;   // 0 random, 1 always ready, 2 hold off
   bit                busy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = DATA_W'(i);
      exp_q.delete();
   endtask

   function automatic exp_t model(input logic cmd, input logic [ADDR_W-1:0] addr,
                                  input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
      exp_t r;
      longint unsigned word;
      int idx;
      word  = 64'(addr) >> 3;
      idx   = int'(word % MEM_WORDS);
      r.tag = tag;
      r.err = 1'b0;
`ifdef MRH_L2_RESP_ERR_EN
      if (word >= MEM_WORDS) begin
         r.err  = 1'b1;
         r.data = '0;
         return r;
      end
`endif
      if (cmd) begin
         mem_m[idx] = data;
         r.data     = data;
      end else begin
         r.data = mem_m[idx];
      end
      return r;
   endfunction

   task automatic issue(input logic cmd, input logic [ADDR_W-1:0] addr,
                        input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
      int n = 0;
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_cmd   = cmd;
      i_req_addr  = addr;
      i_req_tag   = tag;
      i_req_data  = data;
      while (!o_req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!o_req_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL issue_timeout: ready 0 for %0d cycles, required 1", n);
      end else begin
         exp_q.push_back(model(cmd, addr, tag, data));
      end
      @(posedge clk);
      #1 i_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      i_reset = 1'b1;
      model_reset();
      repeat (cycles) @(negedge clk);
      chk("rst_req_ready", o_req_ready, 0);
      chk("rst_resp_valid", o_resp_valid, 0);
      chk("rst_resp_tag", o_resp_tag, 0);
      chk("rst_resp_data", o_resp_data, 0);
`ifdef MRH_L2_RESP_ERR_EN
      chk("rst_resp_err", o_resp_err, 0);
`endif
      i_reset = 1'b0;
      #1 chk("ready_at_deassert", o_req_ready, 0);
      @(posedge clk);
      #1 chk("ready_after_reset", o_req_ready, 1);
   endtask

   // Monitor: drives response ready and checks each presented response against the scoreboard.
   initial begin : monitor
      exp_t              e;
      bit                rdy;
      bit                have_hold;
      logic [TAG_W-1:0]  hold_tag;
      logic [DATA_W-1:0] hold_data;
      have_hold = 1'b0;
      forever begin
         @(negedge clk);
         if (i_reset) begin
            i_resp_ready = 1'b0;
            have_hold    = 1'b0;
         end else begin
            case (rr_mode)
               0:       rdy = 1'($urandom_range(0, 1));
               1:       rdy = 1'b1;
               default: rdy = 1'b0;
            endcase
            i_resp_ready = rdy;
            if (o_resp_valid) begin
               if (have_hold) begin
                  chk("resp_tag_stable", o_resp_tag, hold_tag);
                  chk("resp_data_stable", o_resp_data, hold_data);
               end
               if (rdy) begin
                  have_hold = 1'b0;
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL unexpected_resp: tag %0h data %0h with nothing outstanding",
                              o_resp_tag, o_resp_data);
                  end else begin
                     e = exp_q.pop_front();
                     chk("resp_tag", o_resp_tag, e.tag);
                     chk("resp_data", o_resp_data, e.data);
`ifdef MRH_L2_RESP_ERR_EN
                     chk("resp_err", o_resp_err, e.err);
`endif
                  end
               end else begin
                  have_hold = 1'b1;
                  hold_tag  = o_resp_tag;
                  hold_data = o_resp_data;
               end
            end else begin
               have_hold = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int lat;
      int n;
      model_reset();
      do_reset(3);

      rr_mode = 1;
      issue(1'b0, 'h28, 4'd5, '0);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (o_resp_valid) begin
            lat = k;
            break;
         end
      end
      chk("first_latency", lat, LATENCY + 1);
      wait_drain();

      issue(1'b1, 'h10, 4'd1, 64'hDEAD_BEEF);
      issue(1'b0, 'h10, 4'd2, '0);
      wait_drain();

      issue(1'b0, 'h800, 4'd3, '0);
      wait_drain();

      // Fill the queue with responses held off, then let exactly one drain.
      rr_mode = 2;
      for (int i = 0; i < QDEPTH; i++) begin
         issue(1'b0, ADDR_W'((i + 1) * 8), TAG_W'(i + 8), '0);
      end
      @(negedge clk);
      chk("full_ready", o_req_ready, 0);
      busy = 1'b1;
      fork
         begin
            issue(1'b0, 'h38, 4'hC, '0);
            busy = 1'b0;
         end
      join_none
      n = 0;
      while (!o_resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("held_resp_valid", o_resp_valid, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rr_mode = 1;
      @(posedge clk);
      #1 rr_mode = 2;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("refill_accepted", busy, 0);
      chk("refill_ready", o_req_ready, 0);
      rr_mode = 1;
      wait_drain();

      // Reset with requests outstanding must discard them silently.
      rr_mode = 2;
      issue(1'b0, 'h18, 4'd6, '0);
      issue(1'b0, 'h20, 4'd7, '0);
      issue(1'b0, 'h30, 4'd9, '0);
      repeat (LATENCY + 3) @(negedge clk);
      do_reset(2);
      rr_mode = 1;
      repeat (LATENCY + 3) begin
         @(negedge clk);
         chk("no_resp_after_reset", o_resp_valid, 0);
      end
      issue(1'b0, 'h08, 4'd3, '0);
      wait_drain();

      rr_mode = 0;
      repeat (300) begin
         issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 'h1100)),
               TAG_W'($urandom), DATA_W'({$urandom, $urandom}));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
